// File: rtl/segment_matrix_scanner_pkg.sv
// Shared definitions for the segment matrix scanner.
//   - segment bit indices inside one 8-bit digit byte (active-low a..g, dp)
//   - scan FSM state encoding
//   - glyph table: for every segment, which rows and which cell columns of
//     the 8x4 cell it covers
package segment_matrix_scanner_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    // Row mask per segment (bit r = row r). Leftmost entry is SEG_DP.
    localparam logic [7:0][7:0] SEG_ROWS = '{
        8'h80,  // dp : r7
        8'h08,  // g  : r3
        8'h06,  // f  : r1-2
        8'h30,  // e  : r4-5
        8'h40,  // d  : r6
        8'h30,  // c  : r4-5
        8'h06,  // b  : r1-2
        8'h01   // a  : r0
    };

    // Cell-column mask per segment (bit c = cell column c). Leftmost is SEG_DP.
    localparam logic [7:0][3:0] SEG_COLS = '{
        4'h8,   // dp : c3
        4'h6,   // g  : c1,c2
        4'h1,   // f  : c0
        4'h1,   // e  : c0
        4'h6,   // d  : c1,c2
        4'h8,   // c  : c3
        4'h8,   // b  : c3
        4'h6    // a  : c1,c2
    };

endpackage

// File: rtl/segment_matrix_scanner_glyph.sv
// seg_glyph_cell: combinational glyph decoder for one column of an 8x4 cell.
// Ports:
//   seg      [7:0] active-low segment bits of the selected digit (a..g, dp)
//   cell_col [1:0] column within the digit cell (0..3)
//   rows     [7:0] active-high rows lit in that column (OR of all segments)
module seg_glyph_cell
    import segment_matrix_scanner_pkg::*;
(
    input  logic [7:0] seg,
    input  logic [1:0] cell_col,
    output logic [7:0] rows
);

    always_comb begin
        rows = 8'h00;
        for (int s = 0; s < 8; s++) begin
            if (!seg[s] && SEG_COLS[s][cell_col])
                rows = rows | SEG_ROWS[s];
        end
    end

endmodule

// File: rtl/segment_matrix_scanner.sv
// segment_matrix_scanner: drives NUM_DIGITS 7-segment glyphs onto an
// 8-row x (4*NUM_DIGITS)-column LED matrix by column scanning.
// Each column owns 2^DWELL_W clocks: BLANK_CYC dead-time clocks first, then
// a PWM on-window set by brightness. Segment data is double buffered
// (shadow <- load, display <- shadow at frame start) so frames never tear.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   seg_in            active-low segment bytes, digit d at [8d+7:8d]
//   load              strobe: capture seg_in into the shadow register
//   brightness [3:0]  on-time level, 0 = dark, 15 = brightest
//   row_n [7:0]       active-low row drive (registered)
//   col_n             active-low one-hot column drive (registered)
//   frame_start       one-clock pulse at the first cycle of column 0 (registered)
module segment_matrix_scanner
    import segment_matrix_scanner_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int DWELL_W    = 13,
    parameter int BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [8*NUM_DIGITS-1:0] seg_in,
    input  logic                    load,
    input  logic [3:0]              brightness,
    output logic [7:0]              row_n,
    output logic [4*NUM_DIGITS-1:0] col_n,
    output logic                    frame_start
);

    localparam int NUM_COLS = 4 * NUM_DIGITS;
    localparam int COL_W    = $clog2(NUM_COLS);
    localparam logic [COL_W-1:0]    COL_LAST = COL_W'(NUM_COLS - 1);
    localparam logic [NUM_COLS-1:0] COL_ONE  = NUM_COLS'(1);

    logic [DWELL_W-1:0]      dwell, dwell_nxt;
    logic [COL_W-1:0]        col, col_nxt;
    logic                    dwell_wrap;
    logic                    frame_edge;
    scan_state_e             state, state_nxt;
    logic [8*NUM_DIGITS-1:0] shadow, disp, disp_eff;
    logic [7:0]              sel_seg;
    logic [7:0]              cell_rows;
    logic                    lit;
    logic [7:0]              row_n_d;
    logic [NUM_COLS-1:0]     col_n_d;
    logic                    frame_start_d;

    // ---------------- scan counters ----------------
    assign dwell_wrap = &dwell;
    assign dwell_nxt  = dwell + DWELL_W'(1);
    assign frame_edge = (dwell == '0) && (col == '0);

    always_comb begin
        col_nxt = col;
        if (dwell_wrap)
            col_nxt = (col == COL_LAST) ? '0 : col + COL_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dwell <= '0;
            col   <= '0;
        end else begin
            dwell <= dwell_nxt;
            col   <= col_nxt;
        end
    end

    // ---------------- segment double buffer ----------------
    // A load on the frame edge lands in shadow while display takes the
    // pre-load shadow, because both update on the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '1;
            disp   <= '1;
        end else begin
            if (load)       shadow <= seg_in;
            if (frame_edge) disp   <= shadow;
        end
    end

    // Column 0 cycle 0 must already show the new frame's data (matters when
    // there is no dead time), so bypass the display register on that cycle.
    assign disp_eff = frame_edge ? shadow : disp;

    // ---------------- scan FSM ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_BLANK;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BLANK: if (int'(dwell_nxt) >= BLANK_CYC)   state_nxt = ST_DRIVE;
            ST_DRIVE: if (dwell_wrap && (BLANK_CYC > 0))  state_nxt = ST_BLANK;
            default:                                      state_nxt = ST_BLANK;
        endcase
    end

    // ---------------- glyph lookup on the selected digit ----------------
    always_comb begin
        sel_seg = 8'hFF;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if ((int'(col) >> 2) == d)
                sel_seg = disp_eff[8*d +: 8];
        end
    end

    seg_glyph_cell u_glyph (
        .seg      (sel_seg),
        .cell_col (col[1:0]),
        .rows     (cell_rows)
    );

    // ---------------- output decode ----------------
    // PWM: the top four dwell bits form a 16-step ramp per column period.
    always_comb begin
        lit           = (state == ST_DRIVE) && (dwell[DWELL_W-1 -: 4] < brightness);
        row_n_d       = 8'hFF;
        col_n_d       = '1;
        frame_start_d = frame_edge;
        if (lit) begin
            row_n_d = ~cell_rows;
            col_n_d = ~(COL_ONE << col);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            row_n       <= 8'hFF;
            col_n       <= '1;
            frame_start <= 1'b0;
        end else begin
            row_n       <= row_n_d;
            col_n       <= col_n_d;
            frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_segment_matrix_scanner.sv
// Directed bench for segment_matrix_scanner with NUM_DIGITS=2, DWELL_W=5,
// BLANK_CYC=2: 32 clocks per column, 8 columns, 256-clock frame.
// Outputs are sampled on the falling edge. "off" counts falling edges since
// the last frame_start sample, so the sample at off=k shows the outputs for
// column k/32, dwell k%32.
module tb_segment_matrix_scanner;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] seg_in;
    logic        load;
    logic [3:0]  brightness;
    logic [7:0]  row_n;
    logic [7:0]  col_n;
    logic        frame_start;

    int errors = 0;
    int checks = 0;
    int off    = 0;

    segment_matrix_scanner #(
        .NUM_DIGITS (2),
        .DWELL_W    (5),
        .BLANK_CYC  (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .seg_in      (seg_in),
        .load        (load),
        .brightness  (brightness),
        .row_n       (row_n),
        .col_n       (col_n),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int t);
        while (off < t) begin
            @(negedge clk);
            off++;
        end
    endtask

    // Advance to the next frame boundary and confirm the 256-clock period.
    task automatic frame_end(input string tag);
        goto(256);
        chk(tag, {15'd0, frame_start}, 16'd1);
        off = 0;
    endtask

    task automatic wait_fs(input string tag);
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (frame_start) break;
        end
        chk(tag, {15'd0, frame_start}, 16'd1);
        off = 0;
    endtask

    task automatic do_load(input logic [15:0] v);
        seg_in = v;
        load   = 1'b1;
        @(negedge clk);
        off++;
        load   = 1'b0;
    endtask

    int          lit_cnt [8];
    int          bad;
    logic [7:0]  exp_col;

    initial begin
        reset_n    = 1'b0;
        seg_in     = 16'hFFFF;
        load       = 1'b0;
        brightness = 4'd15;
        repeat (3) @(negedge clk);
        chk("rst_row", {8'h00, row_n}, 16'h00FF);
        chk("rst_col", {8'h00, col_n}, 16'h00FF);
        chk("rst_fs",  {15'd0, frame_start}, 16'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("first_fs", {15'd0, frame_start}, 16'd1);
        off = 0;

        // Mid-scan reset at column 5, then restart from column 0.
        goto(165);
        chk("col5_before_rst", {8'h00, col_n}, 16'h00DF);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_col", {8'h00, col_n}, 16'h00FF);
        chk("async_rst_row", {8'h00, row_n}, 16'h00FF);
        chk("async_rst_fs",  {15'd0, frame_start}, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("fs_after_rel", {15'd0, frame_start}, 16'd1);
        off = 0;
        goto(1);
        chk("blank_dwell1", {8'h00, col_n}, 16'h00FF);
        goto(2);
        chk("col0_after_rel", {8'h00, col_n}, 16'h00FE);

        // "0" on digit 0, digit 1 blank.
        goto(3);
        do_load(16'hFFC0);
        wait_fs("fs_after_load0");
        goto(10);
        chk("c0_row", {8'h00, row_n}, 16'h00C9);
        chk("c0_col", {8'h00, col_n}, 16'h00FE);
        goto(29);
        chk("c0_last_lit", {8'h00, col_n}, 16'h00FE);
        goto(30);
        chk("c0_pwm_off", {8'h00, col_n}, 16'h00FF);
        goto(40);
        chk("c1_row", {8'h00, row_n}, 16'h00BE);
        goto(70);
        chk("c2_row", {8'h00, row_n}, 16'h00BE);
        goto(100);
        chk("c3_row", {8'h00, row_n}, 16'h00C9);
        goto(140);
        chk("c4_row", {8'h00, row_n}, 16'h00FF);
        chk("c4_col", {8'h00, col_n}, 16'h00EF);
        goto(230);
        chk("c7_row", {8'h00, row_n}, 16'h00FF);
        chk("c7_col", {8'h00, col_n}, 16'h007F);
        frame_end("fs_period_a");

        // brightness 0: dark for a whole frame.
        brightness = 4'd0;
        bad = 0;
        while (off < 255) begin
            @(negedge clk);
            off++;
            if (col_n !== 8'hFF) bad++;
        end
        chk("br0_dark", bad[15:0], 16'd0);
        frame_end("fs_period_b");

        // brightness 8: 14 lit cycles per column, one-hot, in order.
        brightness = 4'd8;
        bad = 0;
        for (int c = 0; c < 8; c++) lit_cnt[c] = 0;
        while (off < 255) begin
            @(negedge clk);
            off++;
            if (col_n !== 8'hFF) begin
                exp_col = ~(8'h01 << (off / 32));
                if (col_n !== exp_col) bad++;
                else lit_cnt[off / 32]++;
            end
        end
        chk("br8_onehot_order", bad[15:0], 16'd0);
        for (int c = 0; c < 8; c++) chk($sformatf("br8_cnt_c%0d", c), lit_cnt[c][15:0], 16'd14);
        frame_end("fs_period_c");

        // Mid-frame load: current frame keeps the old glyph.
        brightness = 4'd15;
        goto(40);
        do_load(16'h7F7F);
        goto(100);
        chk("midload_old_c3", {8'h00, row_n}, 16'h00C9);
        frame_end("fs_period_d");
        goto(40);
        chk("midload_new_c1", {8'h00, row_n}, 16'h00FF);
        goto(100);
        chk("midload_dp_c3", {8'h00, row_n}, 16'h007F);
        goto(230);
        chk("midload_dp_c7", {8'h00, row_n}, 16'h007F);

        // Load exactly on the frame edge: old shadow shown this frame.
        goto(255);
        seg_in = 16'hFFF9;
        load   = 1'b1;
        frame_end("fs_period_e");
        load   = 1'b0;
        goto(100);
        chk("edgeload_old_c3", {8'h00, row_n}, 16'h007F);
        goto(230);
        chk("edgeload_old_c7", {8'h00, row_n}, 16'h007F);
        frame_end("fs_period_f");
        goto(100);
        chk("edgeload_new_c3", {8'h00, row_n}, 16'h00C9);
        goto(230);
        chk("edgeload_new_c7", {8'h00, row_n}, 16'h00FF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/segment_matrix_scanner.md
SEGMENT_MATRIX_SCANNER -- requirements
Module: segment_matrix_scanner

Interface
REQ-001 The block SHALL have parameter NUM_DIGITS, default 2, meaning number of 7-segment digits shown side by side (legal 1..4).
REQ-002 The block SHALL have parameter DWELL_W, default 13, meaning width of the per-column dwell counter (column period = 2^DWELL_W clocks, legal 5..16).
REQ-003 The block SHALL have parameter BLANK_CYC, default 16, meaning dead-time clocks at the start of each column period (legal 0..2^(DWELL_W-1)).
REQ-004 The block SHALL have port clk, input, 1, the single system clock.
REQ-005 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 The block SHALL have port seg_in, input, 8*NUM_DIGITS, active-low segments per digit (bit 8d+0..6 = a..g, bit 8d+7 = dp).
REQ-007 The block SHALL have port load, input, 1, single-cycle strobe capturing seg_in into the shadow register.
REQ-008 The block SHALL have port brightness, input, 4, on-time level sampled every cycle (0 = dark, 15 = maximum).
REQ-009 The block SHALL have port row_n, output, 8, active-low row (LED) drive.
REQ-010 The block SHALL have port col_n, output, 4*NUM_DIGITS, active-low one-hot column drive.
REQ-011 The block SHALL have port frame_start, output, 1, one-clock pulse at the first cycle of column 0.

Function
REQ-012 Column index SHALL advance 0..4*NUM_DIGITS-1 and wrap to 0 when the dwell counter wraps from all-ones to zero.
REQ-013 Digit d SHALL occupy columns 4d..4d+3; glyph mapping per 8x4 cell: a=(r0,c1,c2), b=(r1-2,c3), c=(r4-5,c3), d=(r6,c1,c2), e=(r4-5,c0), f=(r1-2,c0), g=(r3,c1,c2), dp=(r7,c3).
REQ-014 A segment SHALL light its cells only when its display-register bit is 0.
REQ-015 Scan FSM SHALL have states BLANK (dwell < BLANK_CYC) and DRIVE (dwell >= BLANK_CYC); BLANK->DRIVE at dwell==BLANK_CYC, DRIVE->BLANK on dwell wrap; BLANK_CYC=0 never enters BLANK after reset.
REQ-016 In BLANK, row_n and col_n SHALL be all ones.
REQ-017 In DRIVE, the column SHALL be lit iff dwell[DWELL_W-1:DWELL_W-4] < brightness; when unlit, row_n and col_n SHALL be all ones.
REQ-018 When lit, col_n SHALL have a single 0 at the current column and row_n SHALL be the inverted OR of all segment cells for that column.
REQ-019 All outputs SHALL be registered, reflecting counter state with exactly one clock latency.
REQ-020 load SHALL copy seg_in into the shadow register on the same edge; the display register SHALL take the shadow value only on the cycle frame_start is asserted (tear-free).
REQ-021 load coincident with the frame boundary SHALL write the shadow, while the display register takes the pre-load shadow value.
REQ-022 brightness changes SHALL take effect on the next cycle without restarting the scan.

Reset
REQ-023 reset_n low SHALL asynchronously force dwell=0, column=0, state BLANK, shadow and display registers all ones (blank), row_n=8'hFF, col_n all ones, frame_start=0.
REQ-024 After reset_n deasserts, the first frame_start SHALL occur on the first clock edge with reset released, and scanning SHALL restart from column 0.

Structure
REQ-025 A shared package SHALL hold the segment index constants (SEG_A..SEG_DP) and the cell-coordinate glyph table.
REQ-026 Glyph decoding SHALL be a combinational sub-module seg_glyph_cell (8 segment bits, 2-bit cell column -> 8 row bits), instantiated once per cycle on the selected digit.

Verification (NUM_DIGITS=2, DWELL_W=5, BLANK_CYC=2)
REQ-027 Reset mid-scan at column 5 -> outputs all ones immediately; frame_start one cycle after release; column 0 next.
REQ-028 load seg_in=16'hFFC0 ("0" on digit 0, digit 1 blank), brightness=15 -> after the next frame_start, column 1 row_n=8'hBE, column 0 row_n=8'hC9, columns 4..7 row_n=8'hFF.
REQ-029 brightness=0 -> col_n=8'hFF for a full frame; brightness=8 -> each column lit exactly 14 of 32 cycles.
REQ-030 load asserted mid-frame with 16'h7F7F -> display unchanged until the next frame_start, then dp at r7,c3 and r7,c7.
REQ-031 load coincident with frame boundary -> old shadow displayed that frame, new value the following frame.
REQ-032 Column sequence check: col_n one-hot low, zero-overlap across blank gaps, wraps 7->0, frame_start period 256 clocks.
